// File: rtl/rc_sup_pkg.sv
// Shared types and constants for the RC link supervisor: FSM encoding,
// error-counter width and the offset-binary neutral value.
package rc_sup_pkg;

  localparam int STATE_W = 2;
  localparam int ERR_W   = 8;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_ARMED    = 2'd2,
    ST_FAILSAFE = 2'd3
  } sup_state_e;

  // Centre code of an offset-binary capture of the given width.
  function automatic int neutral_value(input int res);
    return 1 << (res - 1);
  endfunction

endpackage

// File: rtl/rc_chan_watchdog.sv
// Per-channel plausibility check and signal-loss watchdog.
// Flags each strobed capture as valid or out of range, and tracks link liveness.
module rc_chan_watchdog #(
  parameter int K_RES   = 10,
  parameter int K_WDT_W = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_clear,
  input  logic               i_timebase,
  input  logic               i_capture_done,
  input  logic [K_RES-1:0]   i_capture_value,
  input  logic [K_RES-1:0]   i_min_width,
  input  logic [K_RES-1:0]   i_max_width,
  input  logic [K_WDT_W-1:0] i_timeout,
  output logic               o_valid_capture,
  output logic               o_range_err,
  output logic               o_chan_valid,
  output logic               o_chan_valid_nxt
);

  logic [K_WDT_W-1:0] wdt_q;
  logic [K_WDT_W-1:0] wdt_d;
  logic               seen_q;
  logic               seen_d;
  logic               in_range;

  assign in_range        = (i_capture_value >= i_min_width) && (i_capture_value <= i_max_width);
  assign o_valid_capture = i_capture_done && in_range;
  assign o_range_err     = i_capture_done && !in_range;

  // A valid capture beats a simultaneous tick; the counter parks at all-ones.
  always_comb begin
    wdt_d  = wdt_q;
    seen_d = seen_q;
    if (i_clear) begin
      wdt_d  = '0;
      seen_d = 1'b0;
    end else if (o_valid_capture) begin
      wdt_d  = '0;
      seen_d = 1'b1;
    end else if (i_timebase && (wdt_q != '1)) begin
      wdt_d = wdt_q + K_WDT_W'(1);
    end
  end

  // Flag is judged on the post-update counter so it drops on the cycle wdt hits the limit.
  assign o_chan_valid_nxt = seen_d && (wdt_d < i_timeout);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wdt_q        <= '0;
      seen_q       <= 1'b0;
      o_chan_valid <= 1'b0;
    end else begin
      wdt_q        <= wdt_d;
      seen_q       <= seen_d;
      o_chan_valid <= o_chan_valid_nxt;
    end
  end

endmodule

// File: rtl/rc_link_supervisor.sv
// RC link supervisor: per-channel watchdogs, frame tracking, throttle-neutral
// arming and failsafe sequencing that gates the drive stage.
module rc_link_supervisor
  import rc_sup_pkg::*;
#(
  parameter int K_NCHAN      = 4,
  parameter int K_RES        = 10,
  parameter int K_WDT_W      = 8,
  parameter int K_ARM_FRAMES = 8,
  parameter int K_CHAN_POWER = 1
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_timebase,
  input  logic                            i_enable,
  input  logic [K_NCHAN-1:0]              i_capture_done,
  input  logic [K_NCHAN-1:0][K_RES-1:0]   i_capture_value,
  input  logic [K_RES-1:0]                i_min_width,
  input  logic [K_RES-1:0]                i_max_width,
  input  logic [K_RES-1:0]                i_deadzone,
  input  logic [K_WDT_W-1:0]              i_timeout,
  output logic [STATE_W-1:0]              o_state,
  output logic                            o_armed,
  output logic                            o_failsafe,
  output logic                            o_force_neutral,
  output logic [K_NCHAN-1:0]              o_chan_valid,
  output logic [ERR_W-1:0]                o_err_count
);

  localparam int ARM_W     = $clog2(K_ARM_FRAMES + 1);
  localparam int ERR_SUM_W = ERR_W + 1;
  localparam logic [K_RES:0] NEUTRAL = (K_RES+1)'(neutral_value(K_RES));

  // Capture strobes are single-cycle, valid-only pulses with no back-pressure:
  // a value is sampled exactly in the cycle its strobe is high and never held.
  logic [K_NCHAN-1:0] valid_cap;
  logic [K_NCHAN-1:0] range_err;
  logic [K_NCHAN-1:0] chan_valid_nxt;

  for (genvar g = 0; g < K_NCHAN; g++) begin : g_wdt
    rc_chan_watchdog #(
      .K_RES   (K_RES),
      .K_WDT_W (K_WDT_W)
    ) u_wdt (
      .i_clk            (i_clk),
      .i_rst_n          (i_rst_n),
      .i_clear          (!i_enable),
      .i_timebase       (i_timebase),
      .i_capture_done   (i_capture_done[g]),
      .i_capture_value  (i_capture_value[g]),
      .i_min_width      (i_min_width),
      .i_max_width      (i_max_width),
      .i_timeout        (i_timeout),
      .o_valid_capture  (valid_cap[g]),
      .o_range_err      (range_err[g]),
      .o_chan_valid     (o_chan_valid[g]),
      .o_chan_valid_nxt (chan_valid_nxt[g])
    );
  end

  // Error counter: several channels may be out of range in one cycle.
  logic [ERR_SUM_W-1:0] err_inc;
  logic [ERR_SUM_W-1:0] err_sum;
  logic [ERR_W-1:0]     err_q;

  always_comb begin
    err_inc = '0;
    for (int i = 0; i < K_NCHAN; i++) begin
      err_inc = err_inc + ERR_SUM_W'(range_err[i]);
    end
    err_sum = {1'b0, err_q} + err_inc;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      err_q <= '0;
    end else if (err_sum[ERR_W]) begin
      err_q <= '1;
    end else begin
      err_q <= err_sum[ERR_W-1:0];
    end
  end

  assign o_err_count = err_q;

  // Frame tracking: the cycle the mask reads full is the frame pulse; captures
  // landing in that cycle are discarded rather than seeding the next frame.
  logic [K_NCHAN-1:0] seen_q;
  logic               frame_evt;
  logic [K_RES-1:0]   thr_q;

  assign frame_evt = &seen_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      seen_q <= '0;
      thr_q  <= '0;
    end else if (!i_enable) begin
      seen_q <= '0;
      thr_q  <= '0;
    end else if (frame_evt) begin
      seen_q <= '0;
    end else begin
      seen_q <= seen_q | valid_cap;
      if (valid_cap[K_CHAN_POWER]) begin
        thr_q <= i_capture_value[K_CHAN_POWER];
      end
    end
  end

  // Throttle distance from centre, one bit wider than the capture to keep the sign.
  logic [K_RES:0] thr_diff;
  logic [K_RES:0] thr_mag;
  logic           thr_neutral;

  always_comb begin
    thr_diff    = {1'b0, thr_q} - NEUTRAL;
    thr_mag     = thr_diff[K_RES] ? (~thr_diff + (K_RES+1)'(1)) : thr_diff;
    thr_neutral = thr_mag < {1'b0, i_deadzone};
  end

  // Arming FSM. Including next-cycle validity lets a same-cycle timeout veto arming.
  sup_state_e       state_q;
  sup_state_e       state_d;
  logic [ARM_W-1:0] arm_q;
  logic [ARM_W-1:0] arm_d;
  logic             all_valid;
  logic             links_ok;

  assign all_valid = &o_chan_valid;
  assign links_ok  = all_valid && (&chan_valid_nxt);

  always_comb begin
    state_d = state_q;
    arm_d   = arm_q;
    if (!i_enable) begin
      state_d = ST_IDLE;
      arm_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_ACQUIRE;
          arm_d   = '0;
        end
        ST_ACQUIRE: begin
          if (!links_ok) begin
            arm_d = '0;
          end else if (frame_evt) begin
            if (!thr_neutral) begin
              arm_d = '0;
            end else if (arm_q == ARM_W'(K_ARM_FRAMES - 1)) begin
              arm_d   = '0;
              state_d = ST_ARMED;
            end else begin
              arm_d = arm_q + ARM_W'(1);
            end
          end
        end
        ST_ARMED: begin
          if (!all_valid) begin
            state_d = ST_FAILSAFE;
          end
        end
        ST_FAILSAFE: begin
          if (all_valid) begin
            state_d = ST_ACQUIRE;
            arm_d   = '0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          arm_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      arm_q   <= '0;
    end else begin
      state_q <= state_d;
      arm_q   <= arm_d;
    end
  end

  assign o_state         = state_q;
  assign o_armed         = (state_q == ST_ARMED);
  assign o_failsafe      = (state_q == ST_FAILSAFE);
  assign o_force_neutral = (state_q != ST_ARMED);

endmodule

// File: doc/rc_link_supervisor.md
Name: rc_link_supervisor

Overview:
- Controls the RC channel decode path. Watches the per-channel capture strobes and values from the PWM capture units.
- Decides whether the radio link is healthy and sequences arming/disarming of the drive stage.
- Enforces throttle-neutral arming and failsafe on signal loss. Sits between the per-channel capture units and the motor/steer output logic, and gates their use through o_armed / o_force_neutral.

Parameters:
- K_NCHAN, 4, number of RC channels supervised.
- K_RES, 10, capture value width (offset binary, neutral = 2**(K_RES-1)).
- K_WDT_W, 8, width of per-channel timeout counters and i_timeout.
- K_ARM_FRAMES, 8, consecutive neutral-throttle frames required to arm.
- K_CHAN_POWER, 1, index of the throttle channel.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset.
- i_timebase  in  1  single-cycle tick; watchdog time unit.
- i_enable  in  1  supervisor enable; low forces IDLE.
- i_capture_done  in  K_NCHAN  per-channel single-cycle capture strobe.
- i_capture_value  in  K_NCHAN x K_RES  per-channel captured width, valid with the strobe.
- i_min_width  in  K_RES  lowest plausible pulse width.
- i_max_width  in  K_RES  highest plausible pulse width.
- i_deadzone  in  K_RES  neutral half-window for the throttle arming check.
- i_timeout  in  K_WDT_W  ticks without a valid capture before a channel is lost.
- o_state  out  2  current state (IDLE=0, ACQUIRE=1, ARMED=2, FAILSAFE=3).
- o_armed  out  1  drive stage may use decoded values.
- o_failsafe  out  1  link lost after having been armed.
- o_force_neutral  out  1  downstream must output zero power / centred steer.
- o_chan_valid  out  K_NCHAN  per-channel link-alive flags.
- o_err_count  out  8  saturating count of out-of-range captures.

Behaviour:
- Reset: i_rst_n, asynchronous, active-low; clock i_clk.
- Reset values: o_state=IDLE, o_armed=0, o_failsafe=0, o_force_neutral=1, o_chan_valid=0, o_err_count=0, all internal counters 0, seen mask 0.
- Valid capture: i_capture_done[i]=1 and i_min_width <= value <= i_max_width, unsigned compare.
- Out-of-range capture: strobe with value outside that range. It increments o_err_count, saturating at 255. It does not feed the watchdog.
- Watchdog per channel:
  - Counter wdt[i] clears to 0 on a valid capture, otherwise increments on i_timebase, saturating at all-ones.
  - If a valid capture and a tick occur in the same cycle, the capture wins (counter = 0).
  - o_chan_valid[i] is registered: 1 after at least one valid capture since IDLE and while wdt[i] < i_timeout.
  - i_timeout=0 means every channel is invalid.
- Frame tracking:
  - Seen mask bit i sets on a valid capture.
  - When all bits are set, a frame event pulses internally and the mask clears in the same cycle. Captures arriving that cycle are dropped from the next frame.
- Throttle neutral: |value[K_CHAN_POWER] - 2**(K_RES-1)| < i_deadzone, evaluated on the last valid throttle capture in the frame, with the difference computed at K_RES+1 bits.
- FSM (registered; outputs change the cycle after the condition):
  - IDLE: when i_enable=1, go to ACQUIRE.
  - ACQUIRE:
    - arm_cnt increments on a frame with neutral throttle and all o_chan_valid=1.
    - A frame with non-neutral throttle, or any invalid channel, clears arm_cnt.
    - When arm_cnt reaches K_ARM_FRAMES, go to ARMED.
  - ARMED: o_armed=1, o_force_neutral=0. Any o_chan_valid bit dropping goes to FAILSAFE.
  - FAILSAFE: o_failsafe=1, o_force_neutral=1, o_armed=0. When all channels are valid again, go to ACQUIRE with arm_cnt=0 (re-neutral required).
  - i_enable=0 in any state: go to IDLE next cycle; clear counters, seen mask, arm_cnt and chan_valid. o_err_count is kept.
- Simultaneous events: a timeout in the same cycle as the arming frame means the timeout wins (stay in ACQUIRE, arm_cnt=0). i_enable=0 has priority over everything.
- o_force_neutral = 1 in every state except ARMED.

Decomposition:
- Package rc_sup_pkg: state enum (IDLE/ACQUIRE/ARMED/FAILSAFE), state width, the neutral-constant function of K_RES, and the error-counter width.
- Sub-module rc_chan_watchdog: one per channel via generate. It owns the range check, wdt counter and valid flag, and outputs valid_capture and chan_valid.

Test Plan:
- Arming: K_NCHAN=4, i_timeout=20, all channels captured every 10 ticks at 512, i_deadzone=16 -> ARMED one cycle after the 8th complete frame; o_armed=1, o_force_neutral=0.
- Throttle not neutral: throttle at 700 for 5 frames, then 512 -> no arming until 8 consecutive neutral frames after the last 700 frame.
- Signal loss: in ARMED, stop channel 2 strobes -> o_chan_valid[2] falls when wdt reaches 20; FAILSAFE next cycle, o_failsafe=1, o_armed=0; restore strobes -> ACQUIRE, then ARMED after 8 neutral frames.
- Range errors: i_min_width=100, i_max_width=900, inject captures of 50 and 950 on channel 0 -> o_err_count=2, channel 0 watchdog not refreshed, times out; inject 300 of them -> o_err_count stays at 255.
- Collision: valid capture and i_timebase in the same cycle with wdt=19 -> wdt=0, channel stays valid.
- Enable/reset mid-operation: deassert i_enable in ARMED -> IDLE next cycle, o_force_neutral=1, o_chan_valid=0; assert i_rst_n=0 asynchronously mid-frame -> all outputs at their reset values immediately.
